dispatch_queue: RTL and testbench

//  Elastic FIFO of DEPTH dispatch packets (WIDTH bits each) between rename/dispatch and the
//  222-bit enable-DFF pipeline register that feeds the reservation stations.

---
 rtl/dispatch_queue_if.sv | 33 +++
 rtl/dispatch_queue.sv | 85 ++++++++
 tb/tb_dispatch_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_if.sv
// Handshake bundle between rename/dispatch, the dispatch queue and the RS feed register.
//  in_valid/in_ready/in_data    : upstream packet offer and acceptance
//  out_valid/out_ready/out_data : head packet offer and downstream register enable
//  slave modport  : the queue side
//  master modport : the producer/consumer environment side
interface dispatch_queue_if #(
    parameter int unsigned WIDTH = 222
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/dispatch_queue.sv
// Elastic FIFO of DEPTH dispatch packets sitting in front of the RS feed register.
// Ready toward rename is derived only from registered occupancy, so downstream
// stalls never form a combinational path back into rename.
//  clk         : rising-edge clock
//  reset       : synchronous, active-low
//  flush       : synchronous squash of all entries (mispredict)
//  q           : handshake bundle (slave side), see dispatch_queue_if
//  count       : occupancy 0..DEPTH
//  almost_full : count >= AFULL_LVL
module dispatch_queue #(
    parameter int unsigned WIDTH     = 222,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_LVL = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    dispatch_queue_if.slave        q,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;

    logic can_push;
    logic has_data;
    logic push;
    logic pop;

    // Handshake qualifiers; reset forces both sides idle.
    always_comb begin
        can_push = reset && (cnt_q < CNT_W'(DEPTH));
        has_data = reset && (cnt_q != '0);
        push     = q.in_valid && can_push;
        pop      = has_data && q.out_ready;
    end

    // Pointer and occupancy state; reset dominates flush, flush drops that cycle's transfers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; entries are only ever read while counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= q.in_data;
        end
    end

    // Outputs follow registered state; no write-to-read bypass.
    always_comb begin
        q.in_ready  = can_push;
        q.out_valid = has_data;
        q.out_data  = has_data ? mem[rd_ptr] : '0;
        count       = reset ? cnt_q : '0;
        almost_full = reset && (cnt_q >= CNT_W'(AFULL_LVL));
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: the driver keeps an ideal FIFO of accepted
// packets, the monitor pops it on every downstream handshake and compares data.
module tb_dispatch_queue;

    localparam int unsigned WIDTH = 222;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFULL = 3;

    logic clk;
    logic reset;
    logic flush;
    logic [$clog2(DEPTH):0] count;
    logic almost_full;

    dispatch_queue_if #(.WIDTH(WIDTH)) q ();

    dispatch_queue #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .q           (q),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] exp_q [$];
    int n_cmp  = 0;
    int n_fail = 0;
    logic last_acc;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        logic [WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < 7; i++) begin
            d = (d << 32) | WIDTH'($urandom);
        end
        return d;
    endfunction

    // One clock: drive after the edge, check registered outputs mid-cycle, update model.
    task automatic cyc(input logic rst, input logic fl, input logic iv,
                       input logic [WIDTH-1:0] d, input logic ordy);
        int sz;
        @(posedge clk);
        #1;
        reset       = rst;
        flush       = fl;
        q.in_valid  = iv;
        q.in_data   = d;
        q.out_ready = ordy;
        @(negedge clk);
        last_acc = 1'b0;
        if (!rst) begin
            chk("rst_in_ready",    WIDTH'(q.in_ready),    '0);
            chk("rst_out_valid",   WIDTH'(q.out_valid),   '0);
            chk("rst_out_data",    q.out_data,            '0);
            chk("rst_count",       WIDTH'(count),         '0);
            chk("rst_almost_full", WIDTH'(almost_full),   '0);
            exp_q.delete();
        end else begin
            sz = exp_q.size();
            chk("count",       WIDTH'(count),       WIDTH'(sz));
            chk("in_ready",    WIDTH'(q.in_ready),  WIDTH'(sz < DEPTH));
            chk("out_valid",   WIDTH'(q.out_valid), WIDTH'(sz != 0));
            chk("almost_full", WIDTH'(almost_full), WIDTH'(sz >= AFULL));
            if (sz == 0) chk("out_data_empty", q.out_data, '0);
            else         chk("out_data_head",  q.out_data, exp_q[0]);
            if (fl) begin
                exp_q.delete();
            end else if (iv && sz < DEPTH) begin
                exp_q.push_back(d);
                last_acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b1, 1'b0, 1'b0, '0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 4 && exp_q.size() != 0; i++) idle(1'b1);
        chk("drained", WIDTH'(exp_q.size()), '0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, rnd_data(), 1'b0);
    endtask

    // Monitor: every downstream handshake retires the oldest expected packet.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset === 1'b1 && flush === 1'b0 && q.out_valid === 1'b1 && q.out_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got %h expected no output", q.out_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    n_cmp--;
                    chk("pop_data", q.out_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        q.in_valid  = 1'b0;
        q.in_data   = '0;
        q.out_ready = 1'b0;

        // 1: reset then idle
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b0);

        // 2: fill to full, extra push ignored
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b1, WIDTH'(i), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, WIDTH'(5), 1'b0);
        chk("full_push_ignored", WIDTH'(last_acc), '0);

        // 3: drain while offering 0x5 until it is taken once
        begin
            logic taken;
            taken = 1'b0;
            for (int i = 0; i < 4; i++) begin
                cyc(1'b1, 1'b0, !taken, taken ? '0 : WIDTH'(5), 1'b1);
                if (last_acc) taken = 1'b1;
            end
            chk("five_taken", WIDTH'(taken), WIDTH'(1));
        end
        drain();

        // 4: steady push+pop at count 2, pointers wrap
        fill(2);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, WIDTH'(32'hA0 + i), 1'b1);
        drain();

        // 5: flush with simultaneous push/pop offers, then fresh push
        fill(3);
        cyc(1'b1, 1'b1, 1'b1, WIDTH'(32'hB), 1'b1);
        cyc(1'b1, 1'b0, 1'b1, WIDTH'(32'hC), 1'b0);
        idle(1'b1);
        idle(1'b0);

        // 6: reset beats flush mid-operation
        fill(3);
        cyc(1'b0, 1'b1, 1'b1, WIDTH'(32'hD), 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            logic rst, fl, iv, ordy;
            rst  = ($urandom_range(0, 63) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 5);
            cyc(rst, fl, iv, rnd_data(), ordy);
        end
        drain();
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
